// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if -- bundle of the fetch stage's bus signals.
//
// Groups the instruction SRAM port and the fetch-to-decode handshake so the
// fetch stage and whatever sits around it (decode, SRAM, a bench) connect
// through one port.
//
// Signals
//   inst_sram_en     fetch -> SRAM    read enable
//   inst_sram_addr   fetch -> SRAM    word-aligned fetch address
//   inst_sram_rdata  SRAM  -> fetch   read data, valid the cycle after a read
//   ds_allowin       decode -> fetch  decode can accept an instruction
//   br_taken         decode -> fetch  redirect request (one-cycle pulse)
//   br_target        decode -> fetch  redirect address
//   fs_to_ds_valid   fetch -> decode  fs_pc/fs_inst carry a valid instruction
//   fs_pc            fetch -> decode  PC of the presented instruction
//   fs_inst          fetch -> decode  presented instruction word
//   fs_op            fetch -> decode  fs_inst[31:26], opcode decoder input
//
// Modports
//   master  the fetch stage itself
//   slave   the surrounding SRAM + decode side
// ---------------------------------------------------------------------------
interface if_stage_if;

    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;

    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;

    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic [5:0]  fs_op;

    modport master (
        output inst_sram_en,
        output inst_sram_addr,
        input  inst_sram_rdata,
        input  ds_allowin,
        input  br_taken,
        input  br_target,
        output fs_to_ds_valid,
        output fs_pc,
        output fs_inst,
        output fs_op
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_addr,
        output inst_sram_rdata,
        output ds_allowin,
        output br_taken,
        output br_target,
        input  fs_to_ds_valid,
        input  fs_pc,
        input  fs_inst,
        input  fs_op
    );

endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage.
//
// Issues one instruction SRAM read per cycle whenever the stage can accept a
// new instruction, and presents the returned word to decode one cycle later.
// A one-entry buffer keeps the presented word stable across decode stalls
// even if the SRAM read data changes. Branch redirects from decode either
// take effect immediately (decode accepting) or are parked in a pending
// target until decode accepts, with the newest redirect winning.
//
// Parameters
//   RESET_PC   address of the first fetch after reset
//
// Ports
//   clk        rising-edge clock for all state
//   reset      synchronous, active-high reset
//   bus        if_stage_if.master: SRAM read port + fetch/decode handshake
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input logic          clk,
    input logic          reset,
    if_stage_if.master   bus
);

    // RUN: normal fetch. REDIRECT: a branch arrived while decode was
    // stalled; the current instruction is wrong-path and pend_target holds
    // where to fetch next.
    typedef enum logic {
        StRun,
        StRedirect
    } state_t;

    state_t      state_q, state_d;
    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        br_pend;
    logic        fs_allowin;
    logic        issue;
    logic [31:0] pc_seq;
    logic [31:0] next_pc;
    logic [31:0] fs_inst;

    // A redirect is pending exactly while the FSM is in REDIRECT.
    assign br_pend = (state_q == StRedirect);

    // -----------------------------------------------------------------------
    // Fetch address selection and issue decision
    // -----------------------------------------------------------------------
    always_comb begin
        fs_allowin = !fs_valid_q | bus.ds_allowin;
        pc_seq     = fs_pc_q + 32'd4;

        // Fresh redirect beats a parked one; both beat sequential flow.
        if (bus.br_taken) begin
            next_pc = bus.br_target;
        end else if (br_pend) begin
            next_pc = pend_target_q;
        end else begin
            next_pc = pc_seq;
        end

        issue = !reset & fs_allowin;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        fs_valid_d    = fs_valid_q;
        fs_pc_d       = fs_pc_q;
        inst_buf_d    = inst_buf_q;
        buf_valid_d   = buf_valid_q;
        pend_target_d = pend_target_q;

        if (issue) begin
            // The new fetch replaces whatever was presented, including a
            // wrong-path instruction; any redirect is consumed by next_pc.
            fs_valid_d  = 1'b1;
            fs_pc_d     = next_pc;
            buf_valid_d = 1'b0;
            state_d     = StRun;
        end else begin
            // Redirect that cannot be issued now: park it. A later one
            // overwrites an earlier one.
            if (bus.br_taken) begin
                pend_target_d = bus.br_target;
                state_d       = StRedirect;
            end
            // SRAM data is only guaranteed on the cycle after the read, so
            // latch it on the first stalled cycle.
            if (fs_valid_q && !bus.ds_allowin && !buf_valid_q) begin
                inst_buf_d  = bus.inst_sram_rdata;
                buf_valid_d = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            fs_valid_q    <= 1'b0;
            // One word before RESET_PC so the sequential path fetches RESET_PC.
            fs_pc_q       <= RESET_PC - 32'd4;
            inst_buf_q    <= '0;
            buf_valid_q   <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            fs_valid_q    <= fs_valid_d;
            fs_pc_q       <= fs_pc_d;
            inst_buf_q    <= inst_buf_d;
            buf_valid_q   <= buf_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        fs_inst = buf_valid_q ? inst_buf_q : bus.inst_sram_rdata;

        bus.inst_sram_en   = issue;
        bus.inst_sram_addr = {next_pc[31:2], 2'b00};
        // Never hand over an instruction that a redirect has made stale.
        bus.fs_to_ds_valid = fs_valid_q & !bus.br_taken & !br_pend;
        bus.fs_pc          = fs_pc_q;
        bus.fs_inst        = fs_inst;
        bus.fs_op          = fs_inst[31:26];
    end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- directed bench for if_stage.
//
// The SRAM model returns the read address as data, or a garbage word while
// 'garbage' is set, so presented words can be checked against fs_pc.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic clk;
    logic reset;
    logic garbage;

    int total;
    int bad;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC (32'h1c000000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: data valid the cycle after an enabled read, held otherwise.
    always @(posedge clk) begin
        if (garbage) begin
            bus.inst_sram_rdata <= 32'hdeadbeef;
        end else if (bus.inst_sram_en) begin
            bus.inst_sram_rdata <= bus.inst_sram_addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        garbage        = 1'b0;
        bus.ds_allowin = 1'b1;
        bus.br_taken   = 1'b0;
        bus.br_target  = 32'h0;

        // Reset state
        step();
        step();
        chk("rst_en", {31'b0, bus.inst_sram_en}, 32'd0);
        chk("rst_vld", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        chk("rst_pc", bus.fs_pc, 32'h1bfffffc);

        // Sequential fetch after reset release
        reset = 1'b0;
        #1;
        chk("first_en", {31'b0, bus.inst_sram_en}, 32'd1);
        chk("first_addr", bus.inst_sram_addr, 32'h1c000000);
        step();
        chk("seq0_vld", {31'b0, bus.fs_to_ds_valid}, 32'd1);
        chk("seq0_pc", bus.fs_pc, 32'h1c000000);
        chk("seq0_inst", bus.fs_inst, 32'h1c000000);
        chk("seq0_addr", bus.inst_sram_addr, 32'h1c000004);
        step();
        chk("seq1_pc", bus.fs_pc, 32'h1c000004);
        chk("seq1_inst", bus.fs_inst, 32'h1c000004);
        chk("seq1_addr", bus.inst_sram_addr, 32'h1c000008);
        step();
        chk("seq2_pc", bus.fs_pc, 32'h1c000008);
        chk("seq2_inst", bus.fs_inst, 32'h1c000008);

        // Five-cycle stall with garbage on the SRAM bus
        bus.ds_allowin = 1'b0;
        garbage        = 1'b1;
        #1;
        chk("stall_en0", {31'b0, bus.inst_sram_en}, 32'd0);
        chk("stall_vld0", {31'b0, bus.fs_to_ds_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_inst", bus.fs_inst, 32'h1c000008);
            chk("stall_en", {31'b0, bus.inst_sram_en}, 32'd0);
            chk("stall_pc", bus.fs_pc, 32'h1c000008);
        end
        step();
        bus.ds_allowin = 1'b1;
        garbage        = 1'b0;
        #1;
        chk("rel_en", {31'b0, bus.inst_sram_en}, 32'd1);
        chk("rel_addr", bus.inst_sram_addr, 32'h1c00000c);
        chk("rel_inst", bus.fs_inst, 32'h1c000008);
        step();
        chk("rel_pc", bus.fs_pc, 32'h1c00000c);
        chk("rel_inst2", bus.fs_inst, 32'h1c00000c);

        // Branch with decode accepting
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1c000100;
        #1;
        chk("br_vld", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        chk("br_en", {31'b0, bus.inst_sram_en}, 32'd1);
        chk("br_addr", bus.inst_sram_addr, 32'h1c000100);
        step();
        bus.br_taken = 1'b0;
        #1;
        chk("br_pc", bus.fs_pc, 32'h1c000100);
        chk("br_inst", bus.fs_inst, 32'h1c000100);
        chk("br_op", {26'b0, bus.fs_op}, 32'h07);
        chk("br_vld2", {31'b0, bus.fs_to_ds_valid}, 32'd1);
        chk("br_seq_addr", bus.inst_sram_addr, 32'h1c000104);

        // Branch during stall, overwritten before release
        bus.ds_allowin = 1'b0;
        bus.br_taken   = 1'b1;
        bus.br_target  = 32'h1c000300;
        #1;
        chk("rd_en0", {31'b0, bus.inst_sram_en}, 32'd0);
        chk("rd_vld0", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        step();
        bus.br_taken = 1'b0;
        #1;
        chk("rd_vld1", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        chk("rd_en1", {31'b0, bus.inst_sram_en}, 32'd0);
        step();
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1c000200;
        #1;
        chk("rd_en2", {31'b0, bus.inst_sram_en}, 32'd0);
        step();
        bus.br_taken = 1'b0;
        #1;
        chk("rd_vld3", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        step();
        bus.ds_allowin = 1'b1;
        #1;
        chk("rd_rel_en", {31'b0, bus.inst_sram_en}, 32'd1);
        chk("rd_rel_addr", bus.inst_sram_addr, 32'h1c000200);
        chk("rd_rel_vld", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        step();
        chk("rd_pc", bus.fs_pc, 32'h1c000200);
        chk("rd_inst", bus.fs_inst, 32'h1c000200);
        chk("rd_vld", {31'b0, bus.fs_to_ds_valid}, 32'd1);

        // Address wrap at the top of memory
        bus.br_taken  = 1'b1;
        bus.br_target = 32'hfffffffc;
        #1;
        chk("wrap_br_addr", bus.inst_sram_addr, 32'hfffffffc);
        step();
        bus.br_taken = 1'b0;
        #1;
        chk("wrap_pc", bus.fs_pc, 32'hfffffffc);
        chk("wrap_inst", bus.fs_inst, 32'hfffffffc);
        chk("wrap_op", {26'b0, bus.fs_op}, 32'h3f);
        chk("wrap_addr", bus.inst_sram_addr, 32'h00000000);
        step();
        chk("wrap_pc0", bus.fs_pc, 32'h00000000);
        chk("wrap_inst0", bus.fs_inst, 32'h00000000);

        // Reset during a stall with the buffer full and a redirect pending
        bus.ds_allowin = 1'b0;
        garbage        = 1'b1;
        #1;
        chk("rs_en0", {31'b0, bus.inst_sram_en}, 32'd0);
        step();
        chk("rs_buf", bus.fs_inst, 32'h00000000);
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1c000500;
        #1;
        chk("rs_vld", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        step();
        bus.br_taken = 1'b0;
        reset        = 1'b1;
        #1;
        chk("rs_en1", {31'b0, bus.inst_sram_en}, 32'd0);
        step();
        chk("rs_rst_vld", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        chk("rs_rst_pc", bus.fs_pc, 32'h1bfffffc);
        chk("rs_rst_en", {31'b0, bus.inst_sram_en}, 32'd0);
        reset          = 1'b0;
        garbage        = 1'b0;
        bus.ds_allowin = 1'b1;
        #1;
        chk("rs_re_en", {31'b0, bus.inst_sram_en}, 32'd1);
        chk("rs_re_addr", bus.inst_sram_addr, 32'h1c000000);
        chk("rs_re_vld", {31'b0, bus.fs_to_ds_valid}, 32'd0);
        step();
        chk("rs_re_pc", bus.fs_pc, 32'h1c000000);
        chk("rs_re_inst", bus.fs_inst, 32'h1c000000);
        chk("rs_re_vld2", {31'b0, bus.fs_to_ds_valid}, 32'd1);
        chk("rs_re_addr2", bus.inst_sram_addr, 32'h1c000004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
